soc_event_rr_dispatcher: RTL

//  Next-generation SoC event arbiter. Each event input has a sticky pending latch.

---
 rtl/soc_event_pkg.sv | 11 +
 rtl/soc_event_rr_dispatcher_if.sv | 15 +
 rtl/soc_event_rr_core.sv | 22 ++
 rtl/soc_event_rr_dispatcher.sv | 75 +++++++
 4 files changed

// File: rtl/soc_event_pkg.sv
// Shared constants and helpers for the SoC event dispatcher slice.
package soc_event_pkg;

  localparam int LOST_CNT_W   = 16;
  localparam int EVNT_NUM_DEF = 256;

  function automatic int evt_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_event_rr_dispatcher_if.sv
// Registered valid/ready dispatch port carrying a binary event ID.
interface soc_event_rr_dispatcher_if
  import soc_event_pkg::*;
#(
  parameter int EVNT_NUM = EVNT_NUM_DEF
);
  localparam int ID_W = evt_id_w(EVNT_NUM);

  logic            valid;
  logic [ID_W-1:0] id;
  logic            ready;

  modport master (output valid, id, input  ready);
  modport slave  (input  valid, id, output ready);
endinterface

// File: rtl/soc_event_rr_core.sv
// Stateless round-robin pick: first set bit of req at or after ptr, wrapping to 0.
module soc_event_rr_core #(
  parameter int N    = 256,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] id
);
  logic [N-1:0] req_up;

  assign req_up = req & ({N{1'b1}} << ptr);
  assign any    = |req;

  // Upper half (at/after ptr) overrides the wrapped lowest pick when non-empty.
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i])    id = ID_W'(i);
    for (int i = N - 1; i >= 0; i--) if (req_up[i]) id = ID_W'(i);
  end
endmodule

// File: rtl/soc_event_rr_dispatcher.sv
// Sticky event latches arbitrated in two round-robin classes onto a registered port.
module soc_event_rr_dispatcher
  import soc_event_pkg::*;
#(
  parameter  int EVNT_NUM = EVNT_NUM_DEF,
  localparam int ID_W     = evt_id_w(EVNT_NUM)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [EVNT_NUM-1:0]       evt_i,
  input  logic [EVNT_NUM-1:0]       mask_i,
  input  logic [EVNT_NUM-1:0]       hiprio_i,
  input  logic                      clear_i,
  soc_event_rr_dispatcher_if.master disp,
  output logic [EVNT_NUM-1:0]       pending_o,
  output logic                      lost_valid_o,
  output logic [ID_W-1:0]           lost_id_o,
  output logic [LOST_CNT_W-1:0]     lost_cnt_o
);
  logic [EVNT_NUM-1:0]   pend, elig, hi_req, lo_req, take, lost;
  logic [ID_W-1:0]       ptr_hi, ptr_lo, hi_id, lo_id, winner, lost_low;
  logic                  hi_any, lo_any, load;
  logic [LOST_CNT_W-1:0] lost_cnt;

  assign elig   = pend & ~mask_i;
  assign hi_req = elig & hiprio_i;
  assign lo_req = elig & ~hiprio_i;

  soc_event_rr_core #(.N(EVNT_NUM), .ID_W(ID_W)) u_core_hi (
    .req(hi_req), .ptr(ptr_hi), .any(hi_any), .id(hi_id)
  );
  soc_event_rr_core #(.N(EVNT_NUM), .ID_W(ID_W)) u_core_lo (
    .req(lo_req), .ptr(ptr_lo), .any(lo_any), .id(lo_id)
  );

  assign winner = hi_any ? hi_id : lo_id;
  assign load   = (~disp.valid | disp.ready) & (hi_any | lo_any);
  assign take   = load ? ({{(EVNT_NUM-1){1'b0}}, 1'b1} << winner) : '0;
  // A re-arrival on the bit being loaded this cycle is kept, not counted as lost.
  assign lost   = evt_i & pend & ~take;

  always_comb begin
    lost_low = '0;
    for (int i = EVNT_NUM - 1; i >= 0; i--) if (lost[i]) lost_low = ID_W'(i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend         <= '0;
      ptr_hi       <= '0;
      ptr_lo       <= '0;
      disp.valid   <= 1'b0;
      disp.id      <= '0;
      lost_valid_o <= 1'b0;
      lost_id_o    <= '0;
      lost_cnt     <= '0;
    end else begin
      pend <= clear_i ? evt_i : ((pend & ~take) | evt_i);
      if (load) begin
        disp.valid <= 1'b1;
        disp.id    <= winner;
        if (hi_any) ptr_hi <= winner + 1'b1;
        else        ptr_lo <= winner + 1'b1;
      end else if (disp.ready) begin
        disp.valid <= 1'b0;
      end
      lost_valid_o <= |lost;
      lost_id_o    <= lost_low;
      if (|lost && lost_cnt != '1) lost_cnt <= lost_cnt + 1'b1;
    end
  end

  assign pending_o  = pend;
  assign lost_cnt_o = lost_cnt;
endmodule
